regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The module SHALL have parameter NREQ, default 3, number of requesters (2..4).
REQ-002 The module SHALL have parameter LOCK_MAX, default 8, maximum consecutive grants in one locked burst (1..255).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 The module SHALL have port req, input, NREQ, per-requester write request, held until acked.
REQ-006 The module SHALL have port lock, input, NREQ, per-requester burst-lock request, qualified by req.
REQ-007 The module SHALL have port sel, input, 2*NREQ, target register per requester (requester i at bits 2i+1:2i; 0=a, 1=b, 2=c, 3=d).
REQ-008 The module SHALL have port op, input, NREQ, per-requester operation (0=write, 1=add).
REQ-009 The module SHALL have port wdata, input, 8*NREQ, per-requester operand (requester i at bits 8i+7:8i).
REQ-010 The module SHALL have port ack, output, NREQ, one-hot grant/commit indication, combinational, same cycle as the commit.
REQ-011 The module SHALL have ports a, b, c, d, output, 8 each, the shared registers, driven directly from flops.

Function
REQ-012 The module SHALL assert at most one ack bit per cycle, and ack[i] SHALL imply req[i].
REQ-013 The module SHALL commit the granted requester's op to register sel at the rising edge that ends the ack cycle; the new value SHALL be visible on a/b/c/d the following cycle (latency 1).
REQ-014 Write SHALL replace the register; add SHALL store (reg + wdata) mod 256, with carry discarded.
REQ-015 The module SHALL implement states ARB and LOCKED with an owner index and an 8-bit burst counter.
REQ-016 In ARB, the module SHALL grant the first requesting index at or after pointer ptr (round-robin, wrapping at NREQ), then set ptr = granted+1 mod NREQ.
REQ-017 In ARB, if the granted requester also has lock high, the module SHALL enter LOCKED with owner = granted and count = 1.
REQ-018 In LOCKED, the module SHALL grant only the owner while req[owner] is high, ignoring all other requests, and increment count on each grant.
REQ-019 LOCKED SHALL return to ARB after a cycle in which req[owner] is low (no grant), lock[owner] is low (final grant issued), or count reaches LOCK_MAX (final grant issued).
REQ-020 After a LOCK_MAX release, the owner SHALL be excluded from arbitration for exactly one cycle.
REQ-021 When ptr points at a non-requesting index, the module SHALL skip it; if no requests are present, no ack SHALL be issued and ptr SHALL hold.

Reset
REQ-022 While rst is high, a/b/c/d SHALL load 0, ptr 0, state ARB, count 0, and ack SHALL be all-zero regardless of req.
REQ-023 Reset asserted during LOCKED SHALL abandon the burst and discard the commit of that cycle.

Configuration
REQ-024 With REGFILE_WRITE_ARBITER_ADD_OP_EN defined, op SHALL select add or write per REQ-014.
REQ-025 Without REGFILE_WRITE_ARBITER_ADD_OP_EN, op SHALL be ignored, every commit SHALL be a write, and no adder SHALL be synthesized.

Verification
REQ-026 Reset then idle 4 cycles -> a=b=c=d=0, ack=0 every cycle.
REQ-027 req=3'b111 held, all writes, sel=a, wdata=10/20/30 -> acks in order 0,1,2,0; a=10, 20, 30, 10 on successive cycles.
REQ-028 ADD_OP_EN defined, a=250, requester 1 add 14 to a -> a=8 next cycle; without macro -> a=14.
REQ-029 Requester 0 req+lock held, requester 1 req held, LOCK_MAX=3 -> ack0 for 3 cycles, then ack1, then ack0 resumes.
REQ-030 Requester 2 locked burst, rst pulsed mid-burst -> ack=0 in reset cycle, registers 0, state ARB, ptr 0 afterwards.
REQ-031 Requester 1 locks, drops lock on 2nd grant, d target, wdata 5 then 7 -> two acks, d=7, state ARB.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin write arbiter with locked bursts onto four 8-bit registers.
// Define REGFILE_WRITE_ARBITER_ADD_OP_EN to enable the add operation; otherwise every commit is a write.
module regfile_write_arbiter #(
   parameter int NREQ     = 3,
   parameter int LOCK_MAX = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     lock,
   input  logic [2*NREQ-1:0]   sel,
   input  logic [NREQ-1:0]     op,
   input  logic [8*NREQ-1:0]   wdata,
   output logic [NREQ-1:0]     ack,
   output logic [7:0]          a,
   output logic [7:0]          b,
   output logic [7:0]          c,
   output logic [7:0]          d
);
   typedef enum logic {ARB, LOCKED} state_t;
   state_t state, nstate;
   logic [1:0] ptr, nptr, owner, nowner, gidx, rsel;
   logic [7:0] count, ncount, wd, nv;
   logic [NREQ-1:0] excl, nexcl, cand, own_oh, g_oh;
   logic [7:0] regs [4];
   logic found, last;
   assign own_oh = NREQ'(1) << owner;
   assign cand   = (state == LOCKED) ? (req & own_oh) : (req & ~excl);
   // lowest candidate overall, overridden by the lowest candidate at or after ptr
   always_comb begin
      found = 1'b0;
      gidx  = 2'd0;
      for (int i = NREQ-1; i >= 0; i--) if (cand[i]) begin
         found = 1'b1;
         gidx  = 2'(i);
      end
      for (int i = NREQ-1; i >= 0; i--) if (cand[i] && 2'(i) >= ptr) gidx = 2'(i);
   end
   assign g_oh = found ? (NREQ'(1) << gidx) : '0;
   assign ack  = rst ? '0 : g_oh;
   assign rsel = sel[2*gidx +: 2];
   assign wd   = wdata[8*gidx +: 8];
   assign last = (count + 8'd1) == 8'(LOCK_MAX);
`ifdef REGFILE_WRITE_ARBITER_ADD_OP_EN
   assign nv = |(op & g_oh) ? regs[rsel] + wd : wd;
`else
   logic unused_op;
   assign unused_op = ^op;
   assign nv = wd;
`endif
   always_comb begin
      nstate = state;
      nowner = owner;
      ncount = count;
      nptr   = ptr;
      nexcl  = '0;
      if (state == ARB) begin
         if (found) begin
            nptr = (gidx == 2'(NREQ-1)) ? 2'd0 : gidx + 2'd1;
            if (|(lock & g_oh)) begin
               if (LOCK_MAX == 1) nexcl = g_oh;
               else begin
                  nstate = LOCKED;
                  nowner = gidx;
                  ncount = 8'd1;
               end
            end
         end
      end else if (!found || !(|(lock & own_oh)) || last) begin
         nstate = ARB;
         ncount = 8'd0;
         nexcl  = (found && last) ? g_oh : '0;
      end else ncount = count + 8'd1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB;
         ptr   <= 2'd0;
         owner <= 2'd0;
         count <= 8'd0;
         excl  <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
      end else begin
         state <= nstate;
         ptr   <= nptr;
         owner <= nowner;
         count <= ncount;
         excl  <= nexcl;
         if (found) regs[rsel] <= nv;
      end
   end
   assign a = regs[0];
   assign b = regs[1];
   assign c = regs[2];
   assign d = regs[3];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus random traffic checked against a behavioural model.
module tb_regfile_write_arbiter;
   localparam int N  = 3;
   localparam int LM = 3;
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] req = '0, lock = '0, op = '0, ack;
   logic [2*N-1:0] sel = '0;
   logic [8*N-1:0] wdata = '0;
   logic [7:0] a, b, c, d;
   int errs = 0, checks = 0;
   int m_regs [4];
   int m_ptr = 0, m_own = 0, m_cnt = 0, m_excl = -1;
   bit m_locked = 0, m_valid = 0;
   regfile_write_arbiter #(.NREQ(N), .LOCK_MAX(LM)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .sel(sel), .op(op),
      .wdata(wdata), .ack(ack), .a(a), .b(b), .c(c), .d(d));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // reference model: evaluated mid-cycle with stable inputs, advanced to the next cycle afterwards
   always @(negedge clk) begin
      int g, s, w, ne;
      g = -1;
      if (!rst) begin
         if (m_locked) begin
            if (req[m_own]) g = m_own;
         end else
            for (int k = 0; k < N; k++)
               if (g < 0 && req[(m_ptr + k) % N] && ((m_ptr + k) % N) != m_excl) g = (m_ptr + k) % N;
      end
      chk("model_ack", int'(ack), g >= 0 ? (1 << g) : 0);
      if (m_valid) begin
         chk("model_a", int'(a), m_regs[0]);
         chk("model_b", int'(b), m_regs[1]);
         chk("model_c", int'(c), m_regs[2]);
         chk("model_d", int'(d), m_regs[3]);
      end
      if (rst) begin
         for (int i = 0; i < 4; i++) m_regs[i] = 0;
         m_ptr = 0; m_locked = 0; m_cnt = 0; m_excl = -1; m_valid = 1;
      end else begin
         ne = -1;
         if (g >= 0) begin
            s = int'(sel[2*g +: 2]);
            w = int'(wdata[8*g +: 8]);
`ifdef REGFILE_WRITE_ARBITER_ADD_OP_EN
            m_regs[s] = op[g] ? (m_regs[s] + w) % 256 : w;
`else
            m_regs[s] = w;
`endif
            if (m_locked) begin
               m_cnt++;
               if (m_cnt == LM) begin
                  m_locked = 0;
                  ne = m_own;
               end else if (!lock[m_own]) m_locked = 0;
            end else begin
               m_ptr = (g + 1) % N;
               if (lock[g]) begin
                  if (LM == 1) ne = g;
                  else begin
                     m_locked = 1; m_own = g; m_cnt = 1;
                  end
               end
            end
         end else m_locked = 0;
         m_excl = ne;
      end
   end
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      rst = 1; req = '0; lock = '0; sel = '0; op = '0; wdata = '0;
      step();
      step();
      rst = 0;
   endtask
   initial begin
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         chk("idle_ack", int'(ack), 0);
         chk("idle_regs", int'({a, b, c, d}), 0);
      end
      do_reset();
      req = 3'b111; wdata = {8'd30, 8'd20, 8'd10};
      #1 chk("rr_ack0", int'(ack), 1);
      step(); #1 chk("rr_ack1", int'(ack), 2); chk("rr_a10", int'(a), 10);
      step(); #1 chk("rr_ack2", int'(ack), 4); chk("rr_a20", int'(a), 20);
      step(); #1 chk("rr_ack0b", int'(ack), 1); chk("rr_a30", int'(a), 30);
      step(); #1 chk("rr_a10b", int'(a), 10);
      do_reset();
      req = 3'b001; wdata = {8'd0, 8'd0, 8'd250};
      #1 chk("add_ack0", int'(ack), 1);
      step(); req = 3'b010; op = 3'b010; wdata = {8'd0, 8'd14, 8'd0};
      #1 chk("add_ack1", int'(ack), 2); chk("add_a250", int'(a), 250);
      step(); req = '0; op = '0;
`ifdef REGFILE_WRITE_ARBITER_ADD_OP_EN
      #1 chk("add_result", int'(a), 8);
`else
      #1 chk("add_result", int'(a), 14);
`endif
      do_reset();
      req = 3'b011; lock = 3'b001;
      for (int i = 0; i < 3; i++) begin
         #1 chk("burst_owner", int'(ack), 1);
         step();
      end
      #1 chk("burst_release", int'(ack), 2);
      step(); #1 chk("burst_resume", int'(ack), 1);
      do_reset();
      req = 3'b100; lock = 3'b100; sel = 6'b01_00_00; wdata = {8'd9, 16'd0};
      #1 chk("rstlk_ack_a", int'(ack), 4);
      step(); #1 chk("rstlk_ack_b", int'(ack), 4); chk("rstlk_b9", int'(b), 9);
      step(); rst = 1;
      #1 chk("rstlk_ack_rst", int'(ack), 0);
      step(); rst = 0; req = '0; lock = '0;
      #1 chk("rstlk_b0", int'(b), 0);
      req = 3'b011;
      #1 chk("rstlk_ptr0", int'(ack), 1);
      do_reset();
      req = 3'b010; lock = 3'b010; sel = 6'b00_11_00; wdata = {8'd0, 8'd5, 8'd0};
      #1 chk("unlk_ack_a", int'(ack), 2);
      step(); lock = '0; wdata = {8'd0, 8'd7, 8'd0};
      #1 chk("unlk_ack_b", int'(ack), 2); chk("unlk_d5", int'(d), 5);
      step(); req = '0;
      #1 chk("unlk_idle", int'(ack), 0); chk("unlk_d7", int'(d), 7);
      req = 3'b101;
      #1 chk("unlk_arb", int'(ack), 4);
      for (int n = 0; n < 3000; n++) begin
         step();
         rst   = ($urandom_range(0, 99) == 0);
         req   = 3'($urandom);
         lock  = 3'($urandom) | 3'($urandom);
         sel   = 6'($urandom);
         op    = 3'($urandom);
         wdata = 24'($urandom);
      end
      step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
